// File: rtl/counter_monitor.sv
// Passive checker for a WIDTH-bit up/down counter: predicts each next count, flags mismatches, wraps and faults.
// Latency: a bad dout sampled at edge k shows on mismatch/err_count right after edge k; all outputs registered.
// Backpressure: none, purely observing; it never stalls the counter and samples every cycle.
module counter_monitor #(
  parameter int WIDTH        = 4,
  parameter int ERR_CNT_W    = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dut_rst,
  input  logic                 mode_sel,
  input  logic [WIDTH-1:0]     dout,
  input  logic                 clr,
  output logic                 synced,
  output logic                 mismatch,
  output logic                 fault,
  output logic [WIDTH-1:0]     expected,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_up,
  output logic                 wrap_down
);

  // Consecutive-mismatch counter is wide enough for any threshold in 1..15.
  localparam int CW = 4;

  // TRACK is the only encoding with bit 0 set, so synced is a plain register bit.
  typedef enum logic [1:0] {
    UNSYNC = 2'b00,
    TRACK  = 2'b01,
    FAULT  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            armed_q;       // previous edge was also spent in TRACK
  logic [CW-1:0]   consec_q;
  logic [WIDTH-1:0] prev_dout_q;  // dout seen at the previous edge
  logic [WIDTH-1:0] pred_from_q;  // dout value that would wrap for the predicted direction
  logic            pred_rst_q;
  logic            pred_up_q;

  logic            cmp_en;
  logic            mm_now;
  logic            match_now;
  logic [CW-1:0]   consec_inc;
  logic            enter_fault;
  logic            wrap_hit;
  logic [WIDTH-1:0] expected_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= UNSYNC;
    else     state_q <= state_d;
  end

  // Next state: a counter reset resynchronises; a run of mismatches drops to FAULT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNSYNC:  if (dut_rst) state_d = TRACK;
      TRACK:   if (enter_fault) state_d = FAULT;
      FAULT:   if (dut_rst) state_d = TRACK;
      default: state_d = UNSYNC;
    endcase
  end

  // Per-edge decisions: compare, fault entry, wrap detection and the next prediction.
  always_comb begin
    cmp_en      = (state_q == TRACK) && armed_q;
    mm_now      = cmp_en && (dout != expected);
    match_now   = cmp_en && (dout == expected);
    consec_inc  = (consec_q == '1) ? consec_q : consec_q + CW'(1);
    enter_fault = mm_now && (consec_inc >= CW'(FAULT_THRESH));
    wrap_hit    = match_now && !pred_rst_q && (prev_dout_q == pred_from_q);
    if (dut_rst)       expected_d = '0;
    else if (mode_sel) expected_d = dout + WIDTH'(1);
    else               expected_d = dout - WIDTH'(1);
  end

  assign synced = state_q[0];

  // Predictor, compare results, counters and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q     <= 1'b0;
      consec_q    <= '0;
      prev_dout_q <= '0;
      pred_from_q <= '0;
      pred_rst_q  <= 1'b0;
      pred_up_q   <= 1'b0;
      expected    <= '0;
      mismatch    <= 1'b0;
      wrap_up     <= 1'b0;
      wrap_down   <= 1'b0;
      err_count   <= '0;
      fault       <= 1'b0;
    end else begin
      armed_q     <= (state_q == TRACK) && (state_d == TRACK);
      prev_dout_q <= dout;
      pred_from_q <= mode_sel ? '1 : '0;
      pred_rst_q  <= dut_rst;
      pred_up_q   <= mode_sel;
      expected    <= expected_d;
      mismatch    <= mm_now;
      wrap_up     <= wrap_hit && pred_up_q;
      wrap_down   <= wrap_hit && !pred_up_q;

      if (state_q != TRACK) consec_q <= '0;
      else if (mm_now)      consec_q <= consec_inc;
      else if (match_now)   consec_q <= '0;

      if (clr)                          err_count <= '0;
      else if (mm_now && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);

      if (enter_fault) fault <= 1'b1;
      else if (clr)    fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: each step pushes hand-computed outputs into a scoreboard.
// A negedge monitor pops one entry per cycle and checks two instances (8-bit and 2-bit err_count).
// Asynchronous reset is checked directly between edges.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dut_rst = 1'b0;
  logic       mode_sel = 1'b0;
  logic [3:0] dout = 4'd0;
  logic       clr = 1'b0;

  logic       synced, mismatch, fault, wrap_up, wrap_down;
  logic [3:0] expected;
  logic [7:0] err_count;
  logic       synced2, mismatch2, fault2, wrap_up2, wrap_down2;
  logic [3:0] expected2;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       s;
    logic       mm;
    logic       f;
    logic       wu;
    logic       wd;
    logic [3:0] ex;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  counter_monitor u_dut (
    .clk(clk), .rst(rst), .dut_rst(dut_rst), .mode_sel(mode_sel), .dout(dout), .clr(clr),
    .synced(synced), .mismatch(mismatch), .fault(fault), .expected(expected),
    .err_count(err_count), .wrap_up(wrap_up), .wrap_down(wrap_down)
  );

  counter_monitor #(.ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .dut_rst(dut_rst), .mode_sel(mode_sel), .dout(dout), .clr(clr),
    .synced(synced2), .mismatch(mismatch2), .fault(fault2), .expected(expected2),
    .err_count(err_count2), .wrap_up(wrap_up2), .wrap_down(wrap_down2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_synced"},    32'(synced),    32'd0);
    chk({tag, "_mismatch"},  32'(mismatch),  32'd0);
    chk({tag, "_fault"},     32'(fault),     32'd0);
    chk({tag, "_wrap_up"},   32'(wrap_up),   32'd0);
    chk({tag, "_wrap_down"}, 32'(wrap_down), 32'd0);
    chk({tag, "_expected"},  32'(expected),  32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_synced2"},   32'(synced2),   32'd0);
    chk({tag, "_expected2"}, 32'(expected2), 32'd0);
    chk({tag, "_err2"},      32'(err_count2), 32'd0);
  endtask

  // Drive one sample, let the edge happen, then queue what the outputs must show afterwards.
  task automatic step(input logic dr, input logic ms, input logic [3:0] d, input logic c,
                      input logic s, input logic mm, input logic f, input logic wu,
                      input logic wd, input logic [7:0] er);
    exp_t e;
    @(negedge clk);
    dut_rst = dr; mode_sel = ms; dout = d; clr = c;
    @(posedge clk);
    e.s = s; e.mm = mm; e.f = f; e.wu = wu; e.wd = wd; e.err = er;
    e.ex = dr ? 4'd0 : (ms ? d + 4'd1 : d - 4'd1);
    sb.push_back(e);
  endtask

  // Monitor: one expectation per clock, checked away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [1:0] er2;
      e = sb.pop_front();
      er2 = (e.err > 8'd3) ? 2'd3 : e.err[1:0];
      chk("synced",     32'(synced),     32'(e.s));
      chk("mismatch",   32'(mismatch),   32'(e.mm));
      chk("fault",      32'(fault),      32'(e.f));
      chk("wrap_up",    32'(wrap_up),    32'(e.wu));
      chk("wrap_down",  32'(wrap_down),  32'(e.wd));
      chk("expected",   32'(expected),   32'(e.ex));
      chk("err_count",  32'(err_count),  32'(e.err));
      chk("synced2",    32'(synced2),    32'(e.s));
      chk("mismatch2",  32'(mismatch2),  32'(e.mm));
      chk("fault2",     32'(fault2),     32'(e.f));
      chk("wrap_up2",   32'(wrap_up2),   32'(e.wu));
      chk("wrap_down2", 32'(wrap_down2), 32'(e.wd));
      chk("expected2",  32'(expected2),  32'(e.ex));
      chk("err_count2", 32'(err_count2), 32'(er2));
    end
  end

  initial begin
    // Reset values while rst is held.
    #12;
    chk_zero("reset");
    #1 rst = 1'b0;

    // UNSYNC ignores samples; an X sample on the syncing edge is harmless.
    step(0, 0, 4'd0,    0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'bxxxx, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 4'd0,    0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 4'd0,    0, 1, 0, 0, 0, 0, 0);

    // Real counter counting up 0..15,0..3: one wrap_up on 15->0.
    for (int k = 0; k < 20; k++) begin
      logic [4:0] kk;
      kk = 5'(k);
      step(0, 1, kk[3:0], 0, 1, 0, 0, (k == 16), 0, 0);
    end

    // Counter reset to 0, then down 0 -> 15 -> 14: one wrap_down.
    step(1, 0, 4'd4,  0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 4'd0,  0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 4'd15, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 4'd14, 0, 1, 0, 0, 0, 0, 0);

    // Single bad sample: 3,4,7,8 gives one mismatch on 7; 8 matches 7+1.
    step(1, 1, 4'd13, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd0,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd1,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd2,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd3,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd4,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd7,  0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 4'd8,  0, 1, 0, 0, 0, 0, 1);

    // 2,5,9,12: three consecutive mismatches enter FAULT.
    step(1, 1, 4'd9,  1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd0,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd1,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd2,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd5,  0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 4'd9,  0, 1, 1, 0, 0, 0, 2);
    step(0, 1, 4'd12, 0, 0, 1, 1, 0, 0, 3);
    // In FAULT, bad values are not counted.
    step(0, 1, 4'd0,  0, 0, 0, 1, 0, 0, 3);
    step(0, 1, 4'd7,  0, 0, 0, 1, 0, 0, 3);
    // dut_rst resyncs with fault still set; clr then drops it.
    step(1, 1, 4'd5,  0, 1, 0, 1, 0, 0, 3);
    step(0, 1, 4'd0,  1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd1,  0, 1, 0, 0, 0, 0, 0);

    // Five separate mismatches: 8-bit count reaches 5, 2-bit count saturates at 3.
    step(0, 1, 4'd9,  0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 4'd10, 0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 4'd5,  0, 1, 1, 0, 0, 0, 2);
    step(0, 1, 4'd6,  0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 4'd0,  0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 4'd1,  0, 1, 0, 0, 0, 0, 3);
    step(0, 1, 4'd8,  0, 1, 1, 0, 0, 0, 4);
    step(0, 1, 4'd9,  0, 1, 0, 0, 0, 0, 4);
    step(0, 1, 4'd3,  0, 1, 1, 0, 0, 0, 5);
    step(0, 1, 4'd4,  0, 1, 0, 0, 0, 0, 5);
    // clr with a mismatch on the same edge: count zero, pulse still fires.
    step(0, 1, 4'd12, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 4'd13, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd14, 0, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges, held across one edge.
    #7 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("rst_held");
    rst = 1'b0;

    // After reset, samples are ignored until dut_rst is seen.
    step(0, 1, 4'd7,  0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd3,  0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4'd3,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd0,  0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd1,  0, 1, 0, 0, 0, 0, 0);

    // dut_rst in TRACK still compares that sample (9 vs 2); next prediction is 0.
    step(1, 1, 4'd9,  0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 4'd0,  0, 1, 0, 0, 0, 0, 1);

    // clr on the same edge as FAULT entry: fault wins, err_count cleared.
    step(0, 1, 4'd5,  0, 1, 1, 0, 0, 0, 2);
    step(0, 1, 4'd9,  0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 4'd12, 1, 0, 1, 1, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Passive checker that sits on the output side of the 4-bit up/down counter and consumes what the counter produces. Each cycle it samples the counter's synchronous reset, mode select and count. It predicts the next count, compares it with what actually arrives, and reports mismatches, wrap events, a saturating error count and a sticky fault. Testbenches and on-chip self-test use it alongside any counter instance.

## Interface
- WIDTH, 4: counter width in bits.
- ERR_CNT_W, 8: width of saturating error counter.
- FAULT_THRESH, 3: consecutive mismatches that put the block into FAULT; range 1..15.

- clk  in  1  clock; all sampling on posedge.
- rst  in  1  reset, asynchronous and active-high; one clock domain.
- dut_rst  in  1  the counter's synchronous reset, as driven to the counter.
- mode_sel  in  1  the counter's direction: 1 = up, 0 = down.
- dout  in  WIDTH  the counter's output.
- clr  in  1  synchronous clear of err_count and fault.
- synced  out  1  high while in TRACK.
- mismatch  out  1  one-cycle pulse: the compared sample differed from the prediction.
- fault  out  1  sticky; set on entry to FAULT.
- expected  out  WIDTH  prediction of the value dout will hold after the next edge.
- err_count  out  ERR_CNT_W  total mismatches, saturating.
- wrap_up  out  1  one-cycle pulse on a checked transition from all-ones to 0 by increment.
- wrap_down  out  1  one-cycle pulse on a checked transition from 0 to all-ones by decrement.

## Operation
- States:
  - UNSYNC → TRACK on an edge with dut_rst=1. In UNSYNC, dout is never compared, so X values before the counter's first reset are ignored.
  - TRACK → FAULT when the consecutive-mismatch count reaches FAULT_THRESH.
  - FAULT → TRACK on an edge with dut_rst=1. The consecutive-mismatch count clears; the fault output stays set.
- Prediction is updated at every edge, in every state:
  - expected <= 0 if dut_rst.
  - Otherwise expected <= dout+1 if mode_sel, else dout−1.
  - Arithmetic is modulo 2^WIDTH.
  - The prediction is always built from the observed dout, never from a previous prediction. A single bad sample therefore produces one mismatch, plus at most one more for the step that follows it.
- Predictor flags: pred_rst and pred_up register dut_rst and mode_sel together with expected. pred_from is set to all-ones when up was predicted and to 0 when down was predicted.
- Compare: at each edge in TRACK where the previous edge was also in TRACK, dout is compared against the current expected value.
  - Differ: mismatch=1 for the following cycle, err_count+1 (saturates at all-ones), consecutive count+1.
  - Match: consecutive count clears.
  - On a match with pred_rst=0, wrap_up=1 if pred_up and the previous dout was all-ones.
  - On a match with pred_rst=0, wrap_down=1 if !pred_up and the previous dout was 0.
- The first edge in TRACK, immediately after leaving UNSYNC or FAULT, only forms a prediction and does not compare.
- clr:
  - Zeroes err_count and fault at the edge.
  - clr wins over a mismatch at the same edge: err_count=0, and the mismatch pulse still fires.
  - clr does not change the state.
- fault: set at the edge that enters FAULT. Cleared only by clr or rst. If clr and FAULT entry happen at the same edge, fault=1.
- dut_rst=1 at an edge in TRACK: dout is still compared at that edge; the next prediction is 0.

## Timing
- Reset values: state UNSYNC. synced, mismatch, fault, wrap_up, wrap_down, expected and err_count are all 0, and the internal consecutive count is 0.
- Asserting rst forces all of these immediately (asynchronous). They are held until the first posedge after rst deasserts.
- All outputs are registered.
- Latency:
  - A wrong dout sampled at edge k gives mismatch high from edge k to edge k+1.
  - err_count updates at edge k.
  - fault rises at the edge of the FAULT_THRESH-th consecutive mismatch.
- synced rises at the edge that samples dut_rst=1 from UNSYNC or FAULT.
- wrap_up, wrap_down and mismatch are each exactly one cycle wide per event.

## Test plan
- Reset; dut_rst=1 for 3 edges; then mode_sel=1 for 20 edges with a real counter attached:
  - synced=1 after the first dut_rst edge.
  - mismatch never fires.
  - Exactly one wrap_up, on the 15→0 transition.
  - err_count=0.
- Synced at 0, then mode_sel=0 for 3 edges: dout 0→15→14 gives exactly one wrap_down pulse and no mismatch.
- Bench drives dout directly, synced, mode_sel=1, sequence 3,4,7,8: one mismatch (on 7, expected 5), err_count=1. The following 8 checks against 7+1 and matches; fault=0.
- Sequence 2,5,9,12 with mode_sel=1:
  - Mismatches on 5, 9 and 12; fault=1 and synced=0 after 12.
  - Further bad values leave err_count unchanged at 3.
  - One dut_rst edge gives synced=1 with fault still 1.
  - clr gives fault=0.
- Assert rst asynchronously mid-count, between edges: every output reads 0 before the next posedge. After rst deasserts, samples are ignored (no mismatch) until dut_rst=1 is seen.
- ERR_CNT_W=2: 5 separate mismatches leave err_count at 3. clr together with a mismatch at the same edge gives err_count=0 with mismatch=1.
